// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first.
// SPI_Clk, SPI_MOSI and SPI_CS are oversampled in the d_Clk domain. MOSI bytes are
// deserialised, and a preloaded reply byte is serialised on MISO. A single CS-low
// frame may carry several bytes.
// Optional feature: define SPI_SLAVE_ECHO_EN to send back the last received byte
// whenever no reply byte is loaded at a load point.
module spi_slave_rx_tx #(
    parameter int unsigned SYNC_STAGES  = 2,     // minimum 2
    parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
    input  logic       d_Clk,
    input  logic       reset_l,
    input  logic       SPI_Clk,
    input  logic       SPI_MOSI,
    input  logic       SPI_CS,
    output logic       SPI_MISO,
    output logic       SPI_MISO_en,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       cs_active,
    output logic [7:0] byte_cnt,
    output logic       frame_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   clk_hist_q;
    logic                   cs_hist_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_e     state_q;
    logic [3:0] bit_cnt_q;
    logic [6:0] rx_shift_q;   // first seven bits of the byte in flight
    logic [6:0] tx_shift_q;   // remaining TX bits; bit 7 already sits on SPI_MISO
    logic [7:0] hold_q;
    logic       hold_full_q;
    logic [7:0] reload_byte;
    logic       load_pt;

`ifdef SPI_SLAVE_ECHO_EN
    logic       rx_seen_q;
`endif

    // Input synchronisers plus one history flop for edge detection.
    // The CS chain resets to the idle (high) level so reset release never fakes a CS fall.
    always_ff @(posedge d_Clk or negedge reset_l) begin
        if (!reset_l) begin
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            clk_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], SPI_Clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
            clk_hist_q  <= sclk_s;
            cs_hist_q   <= cs_s;
        end
    end

    // MOSI uses the same path depth as SPI_Clk, so mosi_s is aligned with sclk_rise.
    assign sclk_s    = clk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~clk_hist_q;
    assign sclk_fall = ~sclk_s & clk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;

    // Load points: frame start, and the falling edge that closes a complete byte.
    always_comb begin
        load_pt = 1'b0;
        unique case (state_q)
            StIdle:  load_pt = cs_fall;
            StShift: load_pt = ~cs_rise & sclk_fall & (bit_cnt_q == 4'd8);
            default: load_pt = 1'b0;
        endcase
    end

    // Byte placed in the TX shifter at a load point.
    always_comb begin
        if (hold_full_q) begin
            reload_byte = hold_q;
`ifdef SPI_SLAVE_ECHO_EN
        end else if (rx_seen_q) begin
            reload_byte = rx_byte;
`endif
        end else begin
            reload_byte = IDLE_TX_BYTE;
        end
    end

    // Reply holding register; consumption wins over a same-cycle load request.
    always_ff @(posedge d_Clk or negedge reset_l) begin
        if (!reset_l) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else if (load_pt && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (tx_dv && !hold_full_q) begin
            hold_q      <= tx_byte;
            hold_full_q <= 1'b1;
        end
    end

    assign tx_ready = ~hold_full_q;

    // Frame FSM with registered outputs: shifts RX on rises, drives TX on falls.
    always_ff @(posedge d_Clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 7'd0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_en <= 1'b0;
            rx_dv       <= 1'b0;
            rx_byte     <= 8'h00;
            cs_active   <= 1'b0;
            byte_cnt    <= 8'h00;
            frame_err   <= 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
            rx_seen_q   <= 1'b0;
`endif
        end else begin
            rx_dv     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q     <= StLoad;
                        cs_active   <= 1'b1;
                        SPI_MISO_en <= 1'b1;
                        byte_cnt    <= 8'h00;
                        bit_cnt_q   <= 4'd0;
                        rx_shift_q  <= 7'd0;
                        tx_shift_q  <= reload_byte[6:0];
                        SPI_MISO    <= reload_byte[7];
                    end
                end
                StLoad: begin
                    if (cs_rise) begin
                        state_q     <= StIdle;
                        cs_active   <= 1'b0;
                        SPI_MISO_en <= 1'b0;
                        SPI_MISO    <= 1'b0;
                    end else begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        // A completed byte (count 0 or 8) ends cleanly; anything else is torn.
                        state_q     <= StIdle;
                        cs_active   <= 1'b0;
                        SPI_MISO_en <= 1'b0;
                        SPI_MISO    <= 1'b0;
                        frame_err   <= (bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8);
                        bit_cnt_q   <= 4'd0;
                    end else if (sclk_rise) begin
                        if (bit_cnt_q != 4'd8) begin
                            rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rx_byte <= {rx_shift_q, mosi_s};
                                rx_dv   <= 1'b1;
                                if (byte_cnt != 8'hFF) begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                end
`ifdef SPI_SLAVE_ECHO_EN
                                rx_seen_q <= 1'b1;
`endif
                            end
                        end
                    end else if (sclk_fall) begin
                        if (load_pt) begin
                            tx_shift_q <= reload_byte[6:0];
                            SPI_MISO   <= reload_byte[7];
                            bit_cnt_q  <= 4'd0;
                        end else if (bit_cnt_q != 4'd0) begin
                            tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                            SPI_MISO   <= tx_shift_q[6];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
